// File: rtl/multiport_register_file.sv
// multiport_register_file
// Integer register file for the decode stage: NRD combinational read ports,
// two write ports (WB on port 0, retire path on port 1), and a per-register
// pending scoreboard for hazard detection. x0 is hardwired to zero.
// Optional feature macro: RF_BYPASS_EN forwards same-cycle write data and
// clears rbusy for registers being written in the current cycle.
module multiport_register_file #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we0,
  input  logic [AW-1:0]         wa0,
  input  logic [XLEN-1:0]       wd0,
  input  logic                  we1,
  input  logic [AW-1:0]         wa1,
  input  logic [XLEN-1:0]       wd1,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*XLEN-1:0]   rd,
  output logic [NRD-1:0]        rbusy,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_rd,
  output logic [(1<<AW)-1:0]    busy_vec,
  output logic [AW:0]           busy_cnt
);

  localparam int NREGS = 1 << AW;

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;

  // Next scoreboard state: a new producer (issue) supersedes a completing write.
  always_comb begin
    busy_d    = '0;
    cnt_d     = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (iss_en && (iss_rd == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if ((we0 && (wa0 == AW'(r))) || (we1 && (wa1 == AW'(r)))) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  // Scoreboard bits and their popcount, kept in lockstep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Register array; port 1 is written last so it wins a same-address conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      if (we0 && (wa0 != '0)) begin
        mem_q[wa0] <= wd0;
      end
      if (we1 && (wa1 != '0)) begin
        mem_q[wa1] <= wd1;
      end
    end
  end

  // Combinational read ports; outputs held at zero while reset is asserted.
  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] rdata;
    logic            rb;
    rd    = '0;
    rbusy = '0;
    a     = '0;
    rdata = '0;
    rb    = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      a     = ra[i*AW +: AW];
      rdata = (a == '0) ? '0 : mem_q[a];
      rb    = busy_q[a];
`ifdef RF_BYPASS_EN
      if (a != '0) begin
        if (we1 && (wa1 == a)) begin
          rdata = wd1;
        end else if (we0 && (wa0 == a)) begin
          rdata = wd0;
        end
        if (((we0 && (wa0 == a)) || (we1 && (wa1 == a))) &&
            !(iss_en && (iss_rd == a))) begin
          rb = 1'b0;
        end
      end
`endif
      if (rst) begin
        rd[i*XLEN +: XLEN] = rdata;
        rbusy[i]           = rb;
      end
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench for multiport_register_file (NRD=4). Expected values
// are queued when stimulus is driven and compared once the DUT outputs settle.
// Build with +define+RF_BYPASS_EN to exercise the bypass variant.
module tb_multiport_register_file;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NRD   = 4;
  localparam int NREGS = 32;

  localparam int K_RD  = 0;
  localparam int K_RB  = 1;
  localparam int K_BV  = 2;
  localparam int K_CNT = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                we0, we1, iss_en;
  logic [AW-1:0]       wa0, wa1, iss_rd;
  logic [XLEN-1:0]     wd0, wd1;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic [NREGS-1:0]    busy_vec;
  logic [AW:0]         busy_cnt;

  multiport_register_file #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd), .rbusy(rbusy),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .busy_vec(busy_vec), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [63:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model of architectural state
  logic [XLEN-1:0]  m_mem [NREGS];
  logic [NREGS-1:0] m_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input int idx, input logic [63:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] obs;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      case (e.kind)
        K_RD:    obs = 64'(rd[e.idx*XLEN +: XLEN]);
        K_RB:    obs = 64'(rbusy[e.idx]);
        K_BV:    obs = 64'(busy_vec);
        default: obs = 64'(busy_cnt);
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
    m_busy = '0;
  endtask

  task automatic commit();
    logic [NREGS-1:0] nb;
    nb = m_busy;
    for (int r = 1; r < NREGS; r++) begin
      if (iss_en && iss_rd == 5'(r)) nb[r] = 1'b1;
      else if ((we0 && wa0 == 5'(r)) || (we1 && wa1 == 5'(r))) nb[r] = 1'b0;
    end
    if (we0 && wa0 != '0) m_mem[wa0] = wd0;
    if (we1 && wa1 != '0) m_mem[wa1] = wd1;
    m_busy = nb;
  endtask

  task automatic tick();
    if (rst) commit();
    else     model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    iss_en = 1'b0; iss_rd = '0;
  endtask

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    ra[p*AW +: AW] = a;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we0 = 1'b1; wa0 = a; wd0 = d;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we1 = 1'b1; wa1 = a; wd1 = d;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    iss_en = 1'b1; iss_rd = a;
  endtask

  initial begin
    logic [AW-1:0] a;
    idle();
    ra  = '0;
    rst = 1'b0;
    model_reset();

    // Reset state
    #2;
    push("rst_rd0", K_RD, 0, 0);
    push("rst_cnt", K_CNT, 0, 0);
    push("rst_bv", K_BV, 0, 0);
    drain();
    tick();
    rst = 1'b1;
    tick();

    // Load x5, mark x3 pending, then reset mid-cycle
    wr0(5, 32'hDEADBEEF);
    issue(3);
    tick();
    idle();
    set_ra(0, 5);
    set_ra(1, 3);
    #2;
    push("load_x5", K_RD, 0, 32'hDEADBEEF);
    push("pre_rst_cnt", K_CNT, 0, 1);
    push("pre_rst_rbusy", K_RB, 1, 1);
    drain();
    rst = 1'b0;
    model_reset();
    #1;
    push("async_rst_rd0", K_RD, 0, 0);
    push("async_rst_cnt", K_CNT, 0, 0);
    push("async_rst_bv", K_BV, 0, 0);
    push("async_rst_rbusy", K_RB, 1, 0);
    drain();
    wr0(6, 32'hAB);
    issue(6);
    tick();
    idle();
    rst = 1'b1;
    set_ra(1, 6);
    #2;
    push("post_rst_x5", K_RD, 0, 0);
    push("rst_discard_x6", K_RD, 1, 0);
    push("rst_discard_cnt", K_CNT, 0, 0);
    drain();
    tick();

    // Zero register
    wr0(0, 32'hFFFFFFFF);
    issue(0);
    tick();
    idle();
    set_ra(0, 0);
    #2;
    push("x0_rd", K_RD, 0, 0);
    push("x0_bv", K_BV, 0, 0);
    push("x0_cnt", K_CNT, 0, 0);
    drain();

    // Dual write to the same register: port 1 wins
    wr0(7, 32'h11);
    wr1(7, 32'h22);
    tick();
    idle();
    set_ra(0, 7);
    #2;
    push("dual_wr_x7", K_RD, 0, 32'h22);
    drain();

    // Scoreboard set/clear and set-over-clear priority
    issue(3);
    tick();
    issue(9);
    tick();
    idle();
    #2;
    push("sb_cnt2", K_CNT, 0, 2);
    push("sb_bv2", K_BV, 0, 32'h0000_0208);
    drain();
    wr0(3, 32'h33);
    tick();
    idle();
    #2;
    push("sb_clr_cnt", K_CNT, 0, 1);
    push("sb_clr_bv", K_BV, 0, 32'h0000_0200);
    drain();
    issue(9);
    wr1(9, 32'h99);
    tick();
    idle();
    set_ra(0, 3);
    set_ra(1, 9);
    #2;
    push("sb_prio_cnt", K_CNT, 0, 1);
    push("sb_prio_bv", K_BV, 0, 32'h0000_0200);
    push("sb_prio_rbusy9", K_RB, 1, 1);
    push("sb_prio_x9", K_RD, 1, 32'h99);
    push("sb_x3_free", K_RB, 0, 0);
    push("sb_x3_data", K_RD, 0, 32'h33);
    drain();
    wr0(12, 32'hC);
    tick();
    idle();
    #2;
    push("nonpend_wr_cnt", K_CNT, 0, 1);
    drain();

    // Same-cycle write to a pending register
    wr0(4, 32'h0BAD);
    tick();
    issue(4);
    tick();
    wr0(4, 32'h1234);
    issue(9);
    wr1(9, 32'h999);
    set_ra(0, 4);
    set_ra(1, 9);
    #2;
`ifdef RF_BYPASS_EN
    push("byp_rd0", K_RD, 0, 32'h1234);
    push("byp_rbusy0", K_RB, 0, 0);
    push("byp_rd1", K_RD, 1, 32'h999);
`else
    push("nobyp_rd0", K_RD, 0, 32'h0BAD);
    push("nobyp_rbusy0", K_RB, 0, 1);
    push("nobyp_rd1", K_RD, 1, 32'h99);
`endif
    push("byp_iss_rbusy1", K_RB, 1, 1);
    push("byp_cnt", K_CNT, 0, 2);
    drain();
    tick();
    idle();
    #2;
    push("after_wr_rd0", K_RD, 0, 32'h1234);
    push("after_wr_rbusy0", K_RB, 0, 0);
    push("after_wr_rd1", K_RD, 1, 32'h999);
    push("after_wr_cnt", K_CNT, 0, 1);
    drain();

    // All four read ports at once
    wr0(20, 32'hFFFF);
    wr1(21, 32'h100);
    tick();
    wr0(22, 32'h200);
    wr1(23, 32'h300);
    tick();
    idle();
    wr0(20, 32'h000);
    tick();
    idle();
    for (int p = 0; p < NRD; p++) set_ra(p, 5'(20 + p));
    #2;
    for (int p = 0; p < NRD; p++) push($sformatf("allport%0d", p), K_RD, p, 64'(p * 32'h100));
    drain();

    // Randomised traffic against the model
    for (int it = 0; it < 30; it++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom_range(0, 31)); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = 5'($urandom_range(0, 31)); wd1 = $urandom;
      iss_en = 1'($urandom_range(0, 1)); iss_rd = 5'($urandom_range(0, 31));
      tick();
      idle();
      for (int p = 0; p < NRD; p++) set_ra(p, 5'($urandom_range(0, 31)));
      #2;
      for (int p = 0; p < NRD; p++) begin
        a = ra[p*AW +: AW];
        push($sformatf("rnd%0d_rd%0d", it, p), K_RD, p, (a == '0) ? 64'd0 : 64'(m_mem[a]));
        push($sformatf("rnd%0d_rb%0d", it, p), K_RB, p, 64'(m_busy[a]));
      end
      push($sformatf("rnd%0d_bv", it), K_BV, 0, 64'(m_busy));
      push($sformatf("rnd%0d_cnt", it), K_CNT, 0, 64'($countones(m_busy)));
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised successor to the pipeline's integer register file. Provides NRD combinational read ports, two write ports (WB and a second retire path), and a per-register pending scoreboard for hazard detection. Register 0 is hardwired to zero. Sits in the decode stage: reads feed ID/EX, writes come from write-back, and issue marks destinations pending.

## Interface
- XLEN, 32, data width in bits
- AW, 5, register address width; NREGS = 2**AW
- NRD, 2, number of read ports (1..4)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- we0  in  1  write enable, port 0 (WB)
- wa0  in  AW  write address, port 0
- wd0  in  XLEN  write data, port 0
- we1  in  1  write enable, port 1 (retire path)
- wa1  in  AW  write address, port 1
- wd1  in  XLEN  write data, port 1
- ra  in  NRD*AW  read addresses; port i at bits [i*AW +: AW]
- rd  out  NRD*XLEN  read data; port i at bits [i*XLEN +: XLEN]
- rbusy  out  NRD  port i's register is pending
- iss_en  in  1  issue strobe: mark iss_rd pending
- iss_rd  in  AW  destination being issued
- busy_vec  out  NREGS  registered pending bit per register
- busy_cnt  out  AW+1  registered count of set bits in busy_vec

## Operation
- Storage: NREGS x XLEN array; entry 0 never written, always reads 0.
- Write: at posedge, port p writes when wep=1 and wap!=0. Both ports to the same nonzero address: port 1 data wins.
- Read: rd[i] = array[ra[i]], combinational; ra[i]==0 returns 0.
- Scoreboard, per register r != 0, at posedge:
  - set if iss_en and iss_rd==r
  - else cleared if (we0 and wa0==r) or (we1 and wa1==r)
  - set has priority over clear in the same cycle (new producer supersedes old)
  - busy_vec[0] is always 0; iss_en with iss_rd==0 has no effect
- rbusy[i] = busy_vec[ra[i]], subject to bypass (Configuration).
- busy_cnt: registered next-state popcount, so it always equals popcount(busy_vec) in the same cycle.
- Writes to non-pending registers are legal and leave the scoreboard unchanged.

## Timing
- Reset (rst=0, asynchronous): all array entries 0, busy_vec=0, busy_cnt=0.
- While rst=0: rd forced to 0 and rbusy forced to 0.
- Release is synchronous to the first clk edge with rst=1.
- Write latency: data is visible on rd in the cycle after the write edge; same cycle only with bypass.
- Issue latency: busy_vec and busy_cnt update one edge after iss_en.
- Reset asserted mid-cycle: pending writes and issues are discarded; no partial state.

## Configuration
- RF_BYPASS_EN defined:
  - rd[i] returns same-cycle write data when a write port targets ra[i] != 0; port 1 has priority over port 0.
  - rbusy[i] is 0 when a same-cycle write targets ra[i], unless iss_en targets the same register in that cycle.
- RF_BYPASS_EN undefined: reads and rbusy reflect registered state only; a consumer waits one extra cycle after write-back.

## Test plan
- Reset: load x5=0xDEADBEEF, assert rst=0 -> rd=0 and busy_cnt=0 immediately; after release, reading x5 returns 0.
- Zero register: we0=1, wa0=0, wd0=0xFFFFFFFF, plus iss_en with iss_rd=0 -> rd for x0 is 0, busy_vec[0]=0.
- Dual write conflict: we0/we1 both target x7 with wd0=0x11 and wd1=0x22 -> x7 reads 0x22 next cycle.
- Scoreboard: issue x3, then x9 -> busy_cnt=2. Write x3 -> busy_cnt=1. Issue x9 and write x9 in the same cycle -> x9 stays busy, busy_cnt=1.
- Bypass (RF_BYPASS_EN defined): x4 pending, we0 writes x4=0x1234 while ra[0]=4 -> rd[0]=0x1234 and rbusy[0]=0 in the same cycle. Macro undefined: old value and rbusy[0]=1 in that cycle.
- All ports: NRD=4, each port reads a distinct register loaded with its index*0x100 -> all four values correct simultaneously.
